address_encoder: RTL and testbench
==================================

# address_encoder

Round-robin 16-to-4 request encoder on the data memory side, running in the opposite direction to the 4-to-16 address decoder. Each of 16 requesters raises a request bit. The block latches pending requests, grants one at a time in fair rotating order, and presents the granted index as a 4-bit address with a valid/ready handshake. The consumer is the data memory access controller, which feeds that index back through the address decoder.

## Interface
Parameters:
- N_REQ, 16, number of request lines; fixed at 16 in this design, power of two.
- ADDR_W, 4, encoded address width; must equal log2(N_REQ).

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- REQ  input  16  request bits, sampled every cycle; a one-cycle pulse is sufficient, and a held level re-arms.
- READY  input  1  consumer accepts OUT_E this cycle.
- OUT_E  output  4  registered granted index.
- VALID  output  1  OUT_E holds a grant awaiting acceptance.
- PENDING  output  16  registered pending-request vector, for observability.

## Operation
- Pending register P:
  - Every edge, P <= (P & ~CLR) | REQ.
  - CLR is the one-hot of OUT_E when VALID && READY; otherwise CLR is zero.
  - If REQ sets the same bit that is being cleared in the same cycle, the set wins and the request re-arms.
- Rotation pointer PTR (4 bits): the index to search from first.
- State machine, two states:
  - IDLE: VALID = 0. If P != 0, pick index i = the first set bit of P scanning PTR, PTR+1, …, 15, 0, …, PTR-1, with mod-16 wrap. Load OUT_E <= i, go to PRESENT. If P == 0, stay in IDLE. The search uses the registered P only, not the current-cycle REQ.
  - PRESENT: VALID = 1. OUT_E and VALID stay stable until READY. On VALID && READY: clear bit OUT_E in P, set PTR <= OUT_E + 1 (15 wraps to 0), go to IDLE.
- READY while in IDLE has no effect.
- The granted bit cannot be re-selected until every other pending bit has been granted, unless it is the only one pending.
- Arithmetic: PTR and OUT_E increment mod 16 using plain 4-bit wraparound. No saturation.

## Timing
- Reset values (one edge with RST_N = 0): P = 0, PTR = 0, OUT_E = 0, VALID = 0, state IDLE. REQ sampled during reset is discarded.
- Reset mid-operation: VALID is 0 after the reset edge regardless of handshake state, and a pending grant is lost.
- Latency: REQ bit high at edge k means PENDING shows it after edge k, and VALID/OUT_E are asserted after edge k+1, i.e. 2 cycles from an idle block.
- Throughput: at most one grant per 2 cycles. There is one mandatory IDLE bubble with VALID = 0 after each acceptance.
- Stability: while VALID = 1 and READY = 0, OUT_E holds constant and PTR holds. P may only gain bits.
- Boundary cases:
  - P = 16'hFFFF with PTR = 0 grants 0, 1, …, 15 in order.
  - A lone pending bit below PTR is found via wraparound.
  - REQ = 0 forever keeps the block in IDLE with no spurious VALID.

## Structure
- Shared package dmem_pkg holds:
  - the state enum (ST_IDLE, ST_PRESENT);
  - N_REQ and ADDR_W constants, shared with the address decoder.
- One combinational sub-module, rr_pick. Inputs: P[15:0] and PTR[3:0]. Outputs: idx[3:0] and any (= |P). It implements the rotate, find-first, and un-rotate search.
- The top level holds the P register, PTR, the FSM, and the output registers only.

## Test plan
- Reset: hold RST_N = 0 with REQ = 16'hFFFF for 3 cycles, then release with REQ = 0. Expect VALID = 0, OUT_E = 0, PENDING = 0 throughout reset, then VALID rises 2 cycles after the first post-reset REQ.
- Single pulse: REQ = 16'h0020 for one cycle with READY = 1. Expect PENDING = 16'h0020 the next cycle, then VALID = 1 with OUT_E = 5, then PENDING = 0 and VALID = 0, and PTR advances to 6.
- Full rotation: REQ = 16'hFFFF for one cycle with READY held high. Expect grants 0 through 15 in order, one every 2 cycles, after which PENDING = 0 and VALID stays low.
- Wrap and backpressure: grant index 14 (PTR = 15), then pulse REQ = 16'h0009 with READY = 0 for 5 cycles. Expect OUT_E = 0 held stable with VALID = 1. Raise READY and expect the next grant to be OUT_E = 3.
- Re-arm collision: while OUT_E = 7 is presented, drive REQ bit 7 in the same cycle as READY = 1. Expect bit 7 to remain in PENDING and to be granted again only after the other pending bits.
- Mid-grant reset: with VALID = 1 and OUT_E = 9, assert RST_N = 0 for one edge. Expect VALID = 0, PENDING = 0, and the next grant to search from PTR = 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory request path: request-line count,
// encoded address width and the encoder state type.
package dmem_pkg;

    localparam int N_REQ  = 16;
    localparam int ADDR_W = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/address_encoder_rr_pick.sv
// Combinational round-robin search: first set bit of p at or after ptr,
// wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ  = 16,
    parameter int ADDR_W = 4
) (
    input  logic [N_REQ-1:0]  p,
    input  logic [ADDR_W-1:0] ptr,
    output logic [ADDR_W-1:0] idx,
    output logic              any
);
    import dmem_pkg::*;

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [ADDR_W-1:0]  off;

    always_comb begin
        // Rotate so bit ptr lands at position 0, find-first, then add ptr back.
        dbl = {p, p} >> ptr;
        rot = dbl[N_REQ-1:0];
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = ADDR_W'(i);
        end
        idx = ptr + off;
        any = |p;
    end

endmodule

// File: rtl/address_encoder.sv
// Round-robin 16-to-4 request encoder: latches request pulses, grants one
// index at a time and presents it on a valid/ready handshake.
module address_encoder #(
    parameter int N_REQ  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [N_REQ-1:0]  REQ,
    input  logic              READY,
    output logic [ADDR_W-1:0] OUT_E,
    output logic              VALID,
    output logic [N_REQ-1:0]  PENDING
);
    import dmem_pkg::*;

    state_t             state;
    logic [ADDR_W-1:0]  ptr;
    logic [N_REQ-1:0]   clr;
    logic [ADDR_W-1:0]  pick_idx;
    logic               pick_any;

    rr_pick #(
        .N_REQ  (N_REQ),
        .ADDR_W (ADDR_W)
    ) u_pick (
        .p   (PENDING),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        clr = '0;
        if (VALID && READY) clr[OUT_E] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            PENDING <= '0;
            ptr     <= '0;
            OUT_E   <= '0;
            VALID   <= 1'b0;
            state   <= ST_IDLE;
        end else begin
            // A request arriving on the bit being cleared re-arms it.
            PENDING <= (PENDING & ~clr) | REQ;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        OUT_E <= pick_idx;
                        VALID <= 1'b1;
                        state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (READY) begin
                        ptr   <= OUT_E + ADDR_W'(1);
                        VALID <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    VALID <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_address_encoder.sv
// Directed bench for address_encoder with a queue of expected grant indices.
module tb_address_encoder;

    logic        CLK;
    logic        RST_N;
    logic [15:0] REQ;
    logic        READY;
    logic [3:0]  OUT_E;
    logic        VALID;
    logic [15:0] PENDING;

    int checks = 0;
    int errors = 0;
    logic [3:0] expq[$];

    address_encoder dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .REQ     (REQ),
        .READY   (READY),
        .OUT_E   (OUT_E),
        .VALID   (VALID),
        .PENDING (PENDING)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_grant(input string tag);
        logic [3:0] e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, OUT_E);
        end else begin
            e = expq.pop_front();
            assert (OUT_E === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, OUT_E, e);
            end
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (VALID !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        checks++;
        assert (VALID === 1'b1) else begin
            errors++;
            $error("FAIL %s_timeout observed=%b expected=1", tag, VALID);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        REQ   = 16'hFFFF;
        READY = 1'b0;

        // Reset with all requests high: everything must stay cleared.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_valid", {15'b0, VALID}, 16'h0000);
            chk("rst_oute", {12'b0, OUT_E}, 16'h0000);
            chk("rst_pending", PENDING, 16'h0000);
        end
        RST_N = 1'b1;
        REQ   = 16'h0000;
        step();
        chk("post_rst_pending", PENDING, 16'h0000);
        chk("post_rst_valid", {15'b0, VALID}, 16'h0000);

        // Full rotation from PTR = 0, READY held high.
        READY = 1'b1;
        REQ   = 16'hFFFF;
        for (int i = 0; i < 16; i++) expq.push_back(4'(i));
        step();
        REQ = 16'h0000;
        chk("rot_pending", PENDING, 16'hFFFF);
        chk("rot_latency_valid", {15'b0, VALID}, 16'h0000);
        step();
        for (int i = 0; i < 16; i++) begin
            chk("rot_valid", {15'b0, VALID}, 16'h0001);
            pop_grant("rot_grant");
            step();
            chk("rot_bubble", {15'b0, VALID}, 16'h0000);
            step();
        end
        chk("rot_done_pending", PENDING, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_no_valid", {15'b0, VALID}, 16'h0000);
        end

        // Single pulse on bit 5: PTR was 0 after the rotation wrapped.
        REQ = 16'h0020;
        expq.push_back(4'd5);
        step();
        REQ = 16'h0000;
        chk("pulse_pending", PENDING, 16'h0020);
        chk("pulse_valid_lo", {15'b0, VALID}, 16'h0000);
        step();
        chk("pulse_valid_hi", {15'b0, VALID}, 16'h0001);
        pop_grant("pulse_grant");
        step();
        chk("pulse_clr_pending", PENDING, 16'h0000);
        chk("pulse_clr_valid", {15'b0, VALID}, 16'h0000);

        // Grant 14 so PTR becomes 15.
        REQ = 16'h4000;
        expq.push_back(4'd14);
        step();
        REQ = 16'h0000;
        wait_valid("g14", 4);
        pop_grant("g14_grant");
        step();
        chk("g14_clr", PENDING, 16'h0000);

        // Wraparound with backpressure: bits 0 and 3 pending, PTR = 15.
        READY = 1'b0;
        REQ   = 16'h0009;
        expq.push_back(4'd0);
        expq.push_back(4'd3);
        step();
        REQ = 16'h0000;
        step();
        chk("wrap_valid", {15'b0, VALID}, 16'h0001);
        pop_grant("wrap_grant0");
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", {15'b0, VALID}, 16'h0001);
            chk("bp_oute", {12'b0, OUT_E}, 16'h0000);
            chk("bp_pending", PENDING, 16'h0009);
        end
        READY = 1'b1;
        step();
        chk("bp_accept_valid", {15'b0, VALID}, 16'h0000);
        chk("bp_accept_pending", PENDING, 16'h0008);
        step();
        chk("wrap_next_valid", {15'b0, VALID}, 16'h0001);
        pop_grant("wrap_grant3");
        step();
        chk("wrap_clr", PENDING, 16'h0000);

        // Re-arm collision on bit 7 with bits 2 and 9 also pending (PTR = 4).
        READY = 1'b0;
        REQ   = 16'h0284;
        expq.push_back(4'd7);
        step();
        REQ = 16'h0000;
        step();
        chk("rearm_valid", {15'b0, VALID}, 16'h0001);
        pop_grant("rearm_first");
        READY = 1'b1;
        REQ   = 16'h0080;
        step();
        REQ = 16'h0000;
        chk("rearm_pending", PENDING, 16'h0284);
        expq.push_back(4'd9);
        expq.push_back(4'd2);
        expq.push_back(4'd7);
        for (int i = 0; i < 3; i++) begin
            wait_valid("rearm", 4);
            pop_grant("rearm_order");
            step();
        end
        chk("rearm_done", PENDING, 16'h0000);

        // Mid-grant reset while 9 is presented (PTR = 8 beforehand).
        READY = 1'b0;
        REQ   = 16'h0201;
        expq.push_back(4'd9);
        step();
        REQ = 16'h0000;
        step();
        chk("mid_valid", {15'b0, VALID}, 16'h0001);
        pop_grant("mid_grant");
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        chk("mid_rst_valid", {15'b0, VALID}, 16'h0000);
        chk("mid_rst_pending", PENDING, 16'h0000);
        chk("mid_rst_oute", {12'b0, OUT_E}, 16'h0000);

        // From PTR = 0, bit 1 must win over bit 15.
        READY = 1'b1;
        REQ   = 16'h8002;
        expq.push_back(4'd1);
        expq.push_back(4'd15);
        step();
        REQ = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            wait_valid("post_mid", 4);
            pop_grant("post_mid_grant");
            step();
        end
        chk("final_pending", PENDING, 16'h0000);
        chk("final_valid", {15'b0, VALID}, 16'h0000);

        checks++;
        assert (expq.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_left observed=%0d expected=0", expq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
